// File: rtl/ps2_mouse_packet_assembler_if.sv
// Byte-stream input and packet/position outputs of the PS/2 mouse packet assembler.
// The master side feeds bytes; the slave side is the assembler.
interface ps2_mouse_packet_assembler_if;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic       Rx_error;
  logic [7:0] Status_out;
  logic [7:0] X_Direction;
  logic [7:0] Y_Direction;
  logic       Packet_valid;
  logic       Sync_error;
  logic [9:0] X_Position;
  logic [9:0] Y_Position;

  modport master (
    output Rx_data, Rx_valid, Rx_error,
    input  Status_out, X_Direction, Y_Direction, Packet_valid, Sync_error,
           X_Position, Y_Position
  );

  modport slave (
    input  Rx_data, Rx_valid, Rx_error,
    output Status_out, X_Direction, Y_Direction, Packet_valid, Sync_error,
           X_Position, Y_Position
  );
endinterface

// File: rtl/ps2_mouse_packet_assembler.sv
// Frames PS/2 mouse bytes into 3-byte packets and tracks a clamped absolute cursor.
// Framing recovers on bad sync bytes, receive errors and inter-byte timeouts.
module ps2_mouse_packet_assembler #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479
) (
  input logic                          Clock_100MHz,
  input logic                          Clear_n,
  ps2_mouse_packet_assembler_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [11:0] X_LIM = 12'(X_MAX);
  localparam logic signed [11:0] Y_LIM = 12'(Y_MAX);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  state_t          state_reg;
  logic [CW-1:0]   idle_reg;
  logic [7:0]      b0_reg;
  logic [7:0]      b1_reg;
  logic [7:0]      status_reg;
  logic [7:0]      x_dir_reg;
  logic [7:0]      y_dir_reg;
  logic            pv_reg;
  logic            se_reg;
  logic [9:0]      x_pos_reg;
  logic [9:0]      y_pos_reg;

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] x_sum;
  logic signed [11:0] y_sum;

  always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
    if (!Clear_n) begin
      state_reg  <= WAIT_B0;
      idle_reg   <= '0;
      b0_reg     <= '0;
      b1_reg     <= '0;
      status_reg <= 8'h08;
      x_dir_reg  <= '0;
      y_dir_reg  <= '0;
      pv_reg     <= 1'b0;
      se_reg     <= 1'b0;
    end else begin
      pv_reg <= 1'b0;
      se_reg <= 1'b0;
      // An error strobe beats a simultaneous data strobe.
      if (bus.Rx_error) begin
        state_reg <= WAIT_B0;
        idle_reg  <= '0;
        b0_reg    <= '0;
        b1_reg    <= '0;
        se_reg    <= 1'b1;
      end else if (bus.Rx_valid) begin
        idle_reg <= '0;
        case (state_reg)
          WAIT_B0: begin
            if (bus.Rx_data[3]) begin
              b0_reg    <= bus.Rx_data;
              state_reg <= WAIT_B1;
            end else begin
              se_reg <= 1'b1;
            end
          end
          WAIT_B1: begin
            b1_reg    <= bus.Rx_data;
            state_reg <= WAIT_B2;
          end
          WAIT_B2: begin
            status_reg <= b0_reg;
            x_dir_reg  <= b1_reg;
            y_dir_reg  <= bus.Rx_data;
            pv_reg     <= 1'b1;
            state_reg  <= WAIT_B0;
          end
          default: state_reg <= WAIT_B0;
        endcase
      end else if (state_reg != WAIT_B0) begin
        if (idle_reg == IDLE_LAST) begin
          state_reg <= WAIT_B0;
          idle_reg  <= '0;
          b0_reg    <= '0;
          b1_reg    <= '0;
          se_reg    <= 1'b1;
        end else begin
          idle_reg <= idle_reg + CW'(1);
        end
      end
    end
  end

  // Deltas are 9-bit two's complement with the sign bit carried in the status byte.
  assign dx    = {{4{status_reg[4]}}, x_dir_reg};
  assign dy    = {{4{status_reg[5]}}, y_dir_reg};
  assign x_sum = $signed({2'b00, x_pos_reg}) + dx;
  assign y_sum = $signed({2'b00, y_pos_reg}) - dy;

  function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                       input logic signed [11:0] hi);
    if (v[11])
      return 10'd0;
    else if (v > hi)
      return hi[9:0];
    else
      return v[9:0];
  endfunction

  always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
    if (!Clear_n) begin
      x_pos_reg <= '0;
      y_pos_reg <= '0;
    end else if (pv_reg) begin
      if (!status_reg[6]) x_pos_reg <= clamp(x_sum, X_LIM);
      if (!status_reg[7]) y_pos_reg <= clamp(y_sum, Y_LIM);
    end
  end

  assign bus.Status_out   = status_reg;
  assign bus.X_Direction  = x_dir_reg;
  assign bus.Y_Direction  = y_dir_reg;
  assign bus.Packet_valid = pv_reg;
  assign bus.Sync_error   = se_reg;
  assign bus.X_Position   = x_pos_reg;
  assign bus.Y_Position   = y_pos_reg;

endmodule

// File: tb/tb_ps2_mouse_packet_assembler.sv
// Directed and randomized byte streams against a queue-based packet/cursor model.
module tb_ps2_mouse_packet_assembler;
  localparam int T  = 100;
  localparam int XM = 639;
  localparam int YM = 479;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_mouse_packet_assembler_if bus ();

  ps2_mouse_packet_assembler #(.TIMEOUT_CYCLES(T), .X_MAX(XM), .Y_MAX(YM)) dut (
    .Clock_100MHz (clk),
    .Clear_n      (rst_n),
    .bus          (bus)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Model state: bytes of the packet in progress, last good packet, cursor.
  logic [7:0] partial[$];
  int         idle_cnt;
  logic [7:0] m_status, m_x, m_y;
  bit         m_pv, m_se;
  int         m_xpos, m_ypos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    partial.delete();
    idle_cnt = 0;
    m_status = 8'h08; m_x = 8'h00; m_y = 8'h00;
    m_pv = 0; m_se = 0;
    m_xpos = 0; m_ypos = 0;
  endtask

  // Advance the model across one rising edge that saw inputs (v, e, d).
  task automatic model_edge(input bit v, input bit e, input logic [7:0] d);
    int dxi, dyi;
    if (m_pv) begin
      dxi = m_status[4] ? int'(m_x) - 256 : int'(m_x);
      dyi = m_status[5] ? int'(m_y) - 256 : int'(m_y);
      if (!m_status[6]) m_xpos = clampi(m_xpos + dxi, XM);
      if (!m_status[7]) m_ypos = clampi(m_ypos - dyi, YM);
    end
    m_pv = 0;
    m_se = 0;
    if (e) begin
      partial.delete();
      idle_cnt = 0;
      m_se = 1;
    end else if (v) begin
      idle_cnt = 0;
      if (partial.size() == 0 && !d[3]) begin
        m_se = 1;
      end else begin
        partial.push_back(d);
        if (partial.size() == 3) begin
          m_status = partial[0];
          m_x = partial[1];
          m_y = partial[2];
          m_pv = 1;
          partial.delete();
        end
      end
    end else if (partial.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == T) begin
        partial.delete();
        idle_cnt = 0;
        m_se = 1;
      end
    end
  endtask

  task automatic step(input bit v, input bit e, input logic [7:0] d);
    bus.Rx_valid = v;
    bus.Rx_error = e;
    bus.Rx_data  = d;
    @(posedge clk);
    #1;
    model_edge(v, e, d);
    bus.Rx_valid = 1'b0;
    bus.Rx_error = 1'b0;
    bus.Rx_data  = 8'h00;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    step(1, 0, a);
    step(1, 0, b);
    step(1, 0, c);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_status", bus.Status_out, 8'h08);
    check("rst_xdir", bus.X_Direction, 8'h00);
    check("rst_ydir", bus.Y_Direction, 8'h00);
    check("rst_pv", bus.Packet_valid, 1'b0);
    check("rst_se", bus.Sync_error, 1'b0);
    check("rst_xpos", bus.X_Position, 10'd0);
    check("rst_ypos", bus.Y_Position, 10'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Every cycle out of reset, the DUT must match the model exactly.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("cyc_status", bus.Status_out, m_status);
      check("cyc_xdir", bus.X_Direction, m_x);
      check("cyc_ydir", bus.Y_Direction, m_y);
      check("cyc_pv", bus.Packet_valid, m_pv);
      check("cyc_se", bus.Sync_error, m_se);
      check("cyc_xpos", bus.X_Position, m_xpos[9:0]);
      check("cyc_ypos", bus.Y_Position, m_ypos[9:0]);
    end
  end

  initial begin
    int se_seen;
    int r;
    logic [7:0] d;
    bus.Rx_valid = 1'b0;
    bus.Rx_error = 1'b0;
    bus.Rx_data  = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    cmp_en = 1'b1;

    // First packet from reset.
    send3(8'h09, 8'h05, 8'hFB);
    check("p0_status", bus.Status_out, 8'h09);
    check("p0_xdir", bus.X_Direction, 8'h05);
    check("p0_ydir", bus.Y_Direction, 8'hFB);
    check("p0_pv", bus.Packet_valid, 1'b1);
    step(0, 0, 0);
    check("p0_pv_drop", bus.Packet_valid, 1'b0);
    check("p0_xpos", bus.X_Position, 10'd5);
    check("p0_ypos", bus.Y_Position, 10'd0);

    // Sign extension and clamping at zero.
    do_reset();
    send3(8'h08, 8'h0A, 8'h00); step(0, 0, 0);
    check("x_plus10", bus.X_Position, 10'd10);
    send3(8'h18, 8'hF0, 8'h00); step(0, 0, 0);
    check("x_clamp0", bus.X_Position, 10'd0);
    send3(8'h28, 8'h00, 8'hF6); step(0, 0, 0);
    check("y_down10", bus.Y_Position, 10'd10);

    // X overflow freezes X only.
    send3(8'h08, 8'h0A, 8'h00); step(0, 0, 0);
    send3(8'h48, 8'h7F, 8'h05);
    check("ovf_pv", bus.Packet_valid, 1'b1);
    step(0, 0, 0);
    check("ovf_x", bus.X_Position, 10'd10);
    check("ovf_y", bus.Y_Position, 10'd5);

    // Bad sync byte dropped, then a clean packet.
    step(1, 0, 8'h00);
    check("resync_se", bus.Sync_error, 1'b1);
    send3(8'h08, 8'h01, 8'h01);
    check("resync_pv", bus.Packet_valid, 1'b1);
    check("resync_xdir", bus.X_Direction, 8'h01);
    check("resync_ydir", bus.Y_Direction, 8'h01);

    // Inter-byte timeout.
    step(1, 0, 8'h08);
    step(1, 0, 8'h02);
    se_seen = 0;
    for (int i = 0; i < T + 5; i++) begin
      step(0, 0, 0);
      if (bus.Sync_error) se_seen++;
    end
    check("timeout_pulses", se_seen, 1);
    send3(8'h09, 8'h03, 8'h04);
    check("after_to_status", bus.Status_out, 8'h09);
    check("after_to_xdir", bus.X_Direction, 8'h03);

    // Error wins over a simultaneous byte in the last slot.
    step(1, 0, 8'h08);
    step(1, 0, 8'h11);
    step(1, 1, 8'h22);
    check("prio_pv", bus.Packet_valid, 1'b0);
    check("prio_se", bus.Sync_error, 1'b1);
    check("prio_status", bus.Status_out, 8'h09);
    send3(8'h08, 8'h01, 8'h02);
    check("prio_next_pv", bus.Packet_valid, 1'b1);
    check("prio_next_ydir", bus.Y_Direction, 8'h02);

    // Reset mid-packet drops the partial bytes silently.
    step(0, 0, 0);
    step(1, 0, 8'h08);
    step(1, 0, 8'h01);
    do_reset();
    send3(8'h08, 8'h02, 8'h03);
    check("midrst_status", bus.Status_out, 8'h08);
    check("midrst_xdir", bus.X_Direction, 8'h02);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      d = 8'($urandom);
      if ($urandom_range(0, 99) < 85) d[3] = 1'b1;
      if (r < 45) step(1, 0, d);
      else if (r < 48) step(0, 1, d);
      else if (r < 49) step(1, 1, d);
      else if (r < 50) begin
        r = int'($urandom_range(T - 10, T + 10));
        for (int i = 0; i < r; i++) step(0, 0, 0);
      end else step(0, 0, 0);
    end
    step(0, 0, 0);
    step(0, 0, 0);
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
